// File: rtl/axi_rd_pkg.sv
// Shared codes and FSM state type for the AXI read slave.
package axi_rd_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [3:0] REGION_IRAM = 4'd1;
    localparam logic [3:0] REGION_WRAM = 4'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

    // Bursts this slave cannot serve are answered with SLVERR beats and no RAM access.
    function automatic logic burst_is_err(input logic [2:0] size, input logic [1:0] burst,
                                          input logic [3:0] region, input logic [7:0] len);
        logic bad_wrap_len;
        bad_wrap_len = !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        return (size > 3'd2) || (burst == BURST_RSVD) ||
               !(region == REGION_IRAM || region == REGION_WRAM) ||
               (burst == BURST_WRAP && bad_wrap_len);
    endfunction

endpackage

// File: rtl/axi_read_inft_if.sv
// AXI read address and read data channels.
interface axi_read_inft_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int ID_W   = 8
);
    logic [ID_W-1:0]   ARID;
    logic [ADDR_W-1:0] ARADDR;
    logic [7:0]        ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
    logic [3:0]        ARREGION;
    logic              ARVALID;
    logic              ARREADY;
    logic [ID_W-1:0]   RID;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARREGION, ARVALID, RREADY,
        input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARREGION, ARVALID, RREADY,
        output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );
endinterface

// File: rtl/axi_rd_addr_gen.sv
// Next beat address for FIXED / INCR / WRAP bursts.
module axi_rd_addr_gen
    import axi_rd_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [7:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr
);
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] wrap_mask;

    always_comb begin
        step      = ADDR_W'(1) << size;
        incr      = addr + step;
        // Wrap block is (len+1)*step bytes; len is already restricted to 2^n-1.
        wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
            BURST_INCR:  next_addr = incr;
            default:     next_addr = incr;
        endcase
    end
endmodule

// File: rtl/axi_read_inft.sv
// AXI read slave in front of a 1-cycle-latency internal RAM, one burst at a time.
//   state    | meaning
//   ST_IDLE  | ARREADY high, waiting for an address
//   ST_BURST | issuing RAM reads (or SLVERR beats) as FIFO room allows
//   ST_DRAIN | all beats issued, waiting for the RLAST handshake
module axi_read_inft
    import axi_rd_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int ID_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    axi_read_inft_if.slave    axi,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    output logic [1:0]        ram_rd_region,
    input  logic [DATA_W-1:0] ram_rd_data
);
    rd_state_e         state_q, state_d;
    logic              arready_q, arready_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_nxt;
    logic [7:0]        len_q, len_d;
    logic [7:0]        beat_q, beat_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        burst_q, burst_d;
    logic [1:0]        region_q, region_d;
    logic              err_q, err_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;
    logic [DATA_W-1:0] fifo_data_q [2];
    logic [DATA_W-1:0] fifo_data_d [2];
    logic [1:0]        fifo_last_q, fifo_last_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        occ_q, occ_d;
    logic [1:0]        occ_after_pop;
    logic              pop, push, issue, push_last;
    logic [DATA_W-1:0] push_data;

    axi_rd_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (addr_nxt)
    );

    always_comb begin
        pop           = (occ_q != 2'd0) && axi.RREADY;
        occ_after_pop = occ_q - {1'b0, pop};
        // A beat is issued only if it will have a FIFO slot when its data lands.
        issue         = (state_q == ST_BURST) && ((occ_after_pop + {1'b0, inflight_q}) < 2'd2);
        ram_rd_en     = issue && !err_q;
        push          = inflight_q || (issue && err_q);
        push_data     = inflight_q ? ram_rd_data : '0;
        push_last     = inflight_q ? inflight_last_q : (beat_q == 8'd0);

        state_d         = state_q;
        arready_d       = 1'b0;
        id_d            = id_q;
        addr_d          = addr_q;
        len_d           = len_q;
        beat_d          = beat_q;
        size_d          = size_q;
        burst_d         = burst_q;
        region_d        = region_q;
        err_d           = err_q;
        inflight_d      = ram_rd_en;
        inflight_last_d = (beat_q == 8'd0);
        fifo_data_d     = fifo_data_q;
        fifo_last_d     = fifo_last_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = push_data;
            fifo_last_d[wr_ptr_q] = push_last;
        end
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        occ_d    = occ_q + {1'b0, push} - {1'b0, pop};

        case (state_q)
            ST_IDLE: begin
                arready_d = 1'b1;
                if (arready_q && axi.ARVALID) begin
                    arready_d = 1'b0;
                    id_d      = axi.ARID;
                    addr_d    = axi.ARADDR;
                    len_d     = axi.ARLEN;
                    beat_d    = axi.ARLEN;
                    size_d    = axi.ARSIZE;
                    burst_d   = axi.ARBURST;
                    region_d  = axi.ARREGION[1:0];
                    err_d     = burst_is_err(axi.ARSIZE, axi.ARBURST, axi.ARREGION, axi.ARLEN);
                    state_d   = ST_BURST;
                end
            end
            ST_BURST: begin
                if (issue) begin
                    if (beat_q == 8'd0) begin
                        state_d = ST_DRAIN;
                    end else begin
                        beat_d = beat_q - 8'd1;
                        addr_d = addr_nxt;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && fifo_last_q[rd_ptr_q]) begin
                    state_d   = ST_IDLE;
                    arready_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            arready_q       <= 1'b0;
            id_q            <= '0;
            addr_q          <= '0;
            len_q           <= '0;
            beat_q          <= '0;
            size_q          <= '0;
            burst_q         <= '0;
            region_q        <= '0;
            err_q           <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_data_q[0]  <= '0;
            fifo_data_q[1]  <= '0;
            fifo_last_q     <= '0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            occ_q           <= '0;
        end else begin
            state_q         <= state_d;
            arready_q       <= arready_d;
            id_q            <= id_d;
            addr_q          <= addr_d;
            len_q           <= len_d;
            beat_q          <= beat_d;
            size_q          <= size_d;
            burst_q         <= burst_d;
            region_q        <= region_d;
            err_q           <= err_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            fifo_data_q     <= fifo_data_d;
            fifo_last_q     <= fifo_last_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            occ_q           <= occ_d;
        end
    end

    assign axi.ARREADY   = arready_q;
    assign axi.RVALID    = (occ_q != 2'd0);
    assign axi.RDATA     = fifo_data_q[rd_ptr_q];
    assign axi.RLAST     = (occ_q != 2'd0) && fifo_last_q[rd_ptr_q];
    assign axi.RID       = id_q;
    assign axi.RRESP     = err_q ? RESP_SLVERR : RESP_OKAY;
    assign ram_rd_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign ram_rd_region = region_q;
endmodule

// File: tb/tb_axi_read_inft.sv
// Randomized bench for axi_read_inft against an address-list / RAM-content reference model.
module tb_axi_read_inft;
    import axi_rd_pkg::*;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int ID_W   = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [1:0]        ram_rd_region;
    logic [DATA_W-1:0] ram_rd_data = '0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [ADDR_W+1:0] ram_log[$];
    logic              mon_en = 1'b0;
    logic [ADDR_W-1:0] mon_addr = '0;
    logic [1:0]        mon_reg = '0;

    axi_read_inft_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) axi ();

    axi_read_inft #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .axi           (axi),
        .ram_rd_en     (ram_rd_en),
        .ram_rd_addr   (ram_rd_addr),
        .ram_rd_region (ram_rd_region),
        .ram_rd_data   (ram_rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_W-1:0] a, input logic [1:0] r);
        return (32'(a) * 32'h9E37_79B1) ^ {r, 30'h0123_4567};
    endfunction

    // RAM model: data for a read seen in one cycle is presented throughout the next; junk otherwise.
    always @(negedge clk) begin
        mon_en   <= ram_rd_en;
        mon_addr <= ram_rd_addr;
        mon_reg  <= ram_rd_region;
        if (ram_rd_en) ram_log.push_back({ram_rd_region, ram_rd_addr});
    end

    always @(posedge clk) begin
        ram_rd_data <= mon_en ? ram_word(mon_addr, mon_reg) : DATA_W'($urandom);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit model_err(input logic [2:0] sz, input logic [1:0] bt,
                                     input logic [3:0] rg, input logic [7:0] ln);
        bit wrap_ok;
        wrap_ok = (ln == 1) || (ln == 3) || (ln == 7) || (ln == 15);
        return (sz > 2) || (bt == 2'b11) || !(rg == 1 || rg == 2) || (bt == 2'b10 && !wrap_ok);
    endfunction

    // Address of beat i, computed directly rather than by stepping.
    function automatic logic [ADDR_W-1:0] exp_addr(input logic [ADDR_W-1:0] a, input logic [2:0] sz,
                                                   input logic [7:0] ln, input logic [1:0] bt, input int i);
        int step, blk, base, off;
        step = 1 << sz;
        case (bt)
            2'b00: return a;
            2'b10: begin
                blk  = (int'(ln) + 1) * step;
                base = (int'(a) / blk) * blk;
                off  = (int'(a) - base + i * step) % blk;
                return ADDR_W'(base + off);
            end
            default: return ADDR_W'((int'(a) + i * step) % (1 << ADDR_W));
        endcase
    endfunction

    // rmode: 0 always ready, 1 pattern 1,0,0,1, 2 random. abort_at>0 resets after that many beats.
    task automatic run_burst(input logic [7:0] id, input logic [ADDR_W-1:0] ad, input logic [7:0] ln,
                             input logic [2:0] sz, input logic [1:0] bt, input logic [3:0] rg,
                             input int rmode, input int abort_at);
        bit                err;
        int                beat, cyc, first_cyc, last_cyc, to;
        bit                stalled;
        logic [42:0]       snap, now;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        err = model_err(sz, bt, rg, ln);
        ram_log.delete();
        @(posedge clk); #1;
        axi.ARID = id; axi.ARADDR = ad; axi.ARLEN = ln; axi.ARSIZE = sz;
        axi.ARBURST = bt; axi.ARREGION = rg; axi.ARVALID = 1'b1; axi.RREADY = 1'b0;
        to = 0;
        do begin
            @(negedge clk);
            to++;
        end while (!axi.ARREADY && to < 20);
        check_eq("ar_accept", axi.ARREADY, 1'b1);
        @(posedge clk); #1;
        axi.ARVALID = 1'b0;
        beat = 0; cyc = 0; first_cyc = -1; last_cyc = 0; stalled = 0; snap = '0;
        while (beat <= int'(ln) && cyc < 2000) begin
            cyc++;
            case (rmode)
                0:       axi.RREADY = 1'b1;
                1:       axi.RREADY = ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
                default: axi.RREADY = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (axi.RVALID) begin
                now = {axi.RID, axi.RDATA, axi.RRESP, axi.RLAST};
                if (first_cyc < 0) begin
                    first_cyc = cyc;
                    check_eq("first_rvalid_latency", cyc - 1, err ? 1 : 2);
                end
                if (stalled) check_eq("stall_stable", now, snap);
                if (axi.RREADY) begin
                    ea = exp_addr(ad, sz, ln, bt, beat);
                    ed = err ? '0 : ram_word({ea[ADDR_W-1:2], 2'b00}, rg[1:0]);
                    check_eq("rid", axi.RID, id);
                    check_eq("rdata", axi.RDATA, ed);
                    check_eq("rresp", axi.RRESP, err ? 2'b10 : 2'b00);
                    check_eq("rlast", axi.RLAST, beat == int'(ln));
                    beat++;
                    last_cyc = cyc;
                    stalled = 0;
                    if (abort_at > 0 && beat == abort_at) begin
                        @(posedge clk); #1;
                        rst_n = 1'b0;
                        @(posedge clk); #1;
                        rst_n = 1'b1;
                        ram_log.delete();
                        @(negedge clk);
                        check_eq("rst_rvalid", axi.RVALID, 1'b0);
                        check_eq("rst_arready", axi.ARREADY, 1'b0);
                        @(posedge clk);
                        @(negedge clk);
                        check_eq("post_rst_arready", axi.ARREADY, 1'b1);
                        check_eq("post_rst_rvalid", axi.RVALID, 1'b0);
                        check_eq("post_rst_ram_reads", ram_log.size(), 0);
                        return;
                    end
                end else begin
                    snap = now;
                    stalled = 1;
                end
            end
            @(posedge clk); #1;
        end
        check_eq("beat_count", beat, int'(ln) + 1);
        if (rmode == 0) check_eq("throughput", last_cyc - first_cyc, int'(ln));
        @(negedge clk);
        check_eq("arready_after_last", axi.ARREADY, 1'b1);
        check_eq("rvalid_after_last", axi.RVALID, 1'b0);
        if (err) begin
            check_eq("err_no_ram_reads", ram_log.size(), 0);
        end else begin
            check_eq("ram_read_count", ram_log.size(), int'(ln) + 1);
            for (int i = 0; i < ram_log.size() && i <= int'(ln); i++) begin
                ea = exp_addr(ad, sz, ln, bt, i);
                check_eq("ram_rd_addr", ram_log[i], {rg[1:0], ea[ADDR_W-1:2], 2'b00});
            end
        end
    endtask

    initial begin
        logic [1:0] bt;
        logic [2:0] sz;
        logic [3:0] rg;
        logic [7:0] ln;
        axi.ARID = '0; axi.ARADDR = '0; axi.ARLEN = '0; axi.ARSIZE = '0;
        axi.ARBURST = '0; axi.ARREGION = '0; axi.ARVALID = 1'b0; axi.RREADY = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_arready", axi.ARREADY, 1'b0);
        check_eq("rst_rvalid", axi.RVALID, 1'b0);
        check_eq("rst_rlast", axi.RLAST, 1'b0);
        check_eq("rst_rid", axi.RID, 0);
        check_eq("rst_rdata", axi.RDATA, 0);
        check_eq("rst_rresp", axi.RRESP, 0);
        check_eq("rst_ram_rd_en", ram_rd_en, 1'b0);
        check_eq("rst_ram_rd_addr", ram_rd_addr, 0);
        check_eq("rst_ram_rd_region", ram_rd_region, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("arready_after_reset", axi.ARREADY, 1'b1);

        run_burst(8'd1, 11'h000, 8'd3, 3'd2, BURST_INCR, REGION_IRAM, 0, 0);
        run_burst(8'd2, 11'h018, 8'd3, 3'd2, BURST_WRAP, REGION_WRAM, 0, 0);
        run_burst(8'd3, 11'h7FC, 8'd1, 3'd2, BURST_INCR, REGION_IRAM, 0, 0);
        run_burst(8'd4, 11'h040, 8'd2, 3'd2, BURST_INCR, 4'd0, 0, 0);
        run_burst(8'd6, 11'h100, 8'd0, 3'd2, BURST_FIXED, REGION_WRAM, 0, 0);
        run_burst(8'd7, 11'h200, 8'd7, 3'd2, BURST_INCR, REGION_IRAM, 1, 0);
        run_burst(8'd8, 11'h300, 8'd7, 3'd2, BURST_INCR, REGION_IRAM, 0, 2);
        run_burst(8'd5, 11'h080, 8'd3, 3'd2, BURST_INCR, REGION_WRAM, 0, 0);

        for (int n = 0; n < 40; n++) begin
            bt = 2'($urandom_range(0, 3));
            if (bt == 2'b11 && $urandom_range(0, 3) != 0) bt = BURST_INCR;
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            rg = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 2));
            if (bt == BURST_WRAP && $urandom_range(0, 4) != 0) begin
                case ($urandom_range(0, 3))
                    0:       ln = 8'd1;
                    1:       ln = 8'd3;
                    2:       ln = 8'd7;
                    default: ln = 8'd15;
                endcase
            end else begin
                ln = 8'($urandom_range(0, 15));
            end
            run_burst(8'($urandom), ADDR_W'($urandom), ln, sz, bt, rg, int'($urandom_range(0, 2)), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_read_inft.md
AXI_READ_INFT -- requirements
Module: axi_read_inft

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, byte-address width of ARADDR and ram_rd_addr.
REQ-002 SHALL have parameter DATA_W, default 32, width of RDATA and ram_rd_data.
REQ-003 SHALL have parameter ID_W, default 8, width of ARID and RID.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-006 SHALL have port ARID  in  ID_W  read transaction ID.
REQ-007 SHALL have port ARADDR  in  ADDR_W  start byte address.
REQ-008 SHALL have port ARLEN  in  8  beats minus one.
REQ-009 SHALL have port ARSIZE  in  3  log2 bytes per beat.
REQ-010 SHALL have port ARBURST  in  2  00 FIXED, 01 INCR, 10 WRAP.
REQ-011 SHALL have port ARREGION  in  4  target: 1 IRAM, 2 WRAM.
REQ-012 SHALL have port ARVALID  in  1  address valid.
REQ-013 SHALL have port ARREADY  out  1  address accepted.
REQ-014 SHALL have port RID  out  ID_W  ID of the current burst.
REQ-015 SHALL have port RDATA  out  DATA_W  read data.
REQ-016 SHALL have port RRESP  out  2  00 OKAY, 10 SLVERR.
REQ-017 SHALL have port RLAST  out  1  final beat of burst.
REQ-018 SHALL have port RVALID  out  1  beat valid.
REQ-019 SHALL have port RREADY  in  1  master accepts beat.
REQ-020 SHALL have port ram_rd_en  out  1  internal RAM read strobe.
REQ-021 SHALL have port ram_rd_addr  out  ADDR_W  word-aligned byte address.
REQ-022 SHALL have port ram_rd_region  out  2  ARREGION[1:0] of the burst.
REQ-023 SHALL have port ram_rd_data  in  DATA_W  RAM data, valid exactly 1 cycle after ram_rd_en.

Function
REQ-024 SHALL hold one burst at a time; FSM states IDLE, BURST, DRAIN.
REQ-025 IDLE: ARREADY=1; on ARVALID&ARREADY capture all AR fields, set beat counter to ARLEN, go BURST; ARREADY=0 outside IDLE.
REQ-026 Burst SHALL be flagged error when ARSIZE>2, ARBURST=11, ARREGION not in {1,2}, or WRAP with ARLEN not in {1,3,7,15}.
REQ-027 Error burst: no ram_rd_en; return ARLEN+1 beats, RDATA=0, RRESP=10; otherwise RRESP=00.
REQ-028 Output path SHALL be a 2-entry FIFO; ram_rd_en issued only when FIFO occupancy plus reads in flight < 2, so full throughput (one beat per cycle) is sustained with RREADY held high.
REQ-029 First RVALID SHALL appear 2 cycles after AR handshake (non-error) or 1 cycle (error).
REQ-030 Address step = 1<<ARSIZE; FIXED: constant; INCR: add step modulo 2^ADDR_W; WRAP: wrap within aligned block of (ARLEN+1)*step bytes.
REQ-031 After the last read is issued go DRAIN; return to IDLE in the cycle the RLAST beat handshakes; next AR may be accepted the following cycle.
REQ-032 RVALID, RDATA, RRESP, RLAST, RID SHALL stay stable while RVALID=1 and RREADY=0.
REQ-033 RLAST=1 only on beat ARLEN+1; ARLEN=0 yields a single beat with RLAST=1.
REQ-034 ram_rd_addr SHALL have bits [1:0] forced to 0.

Reset
REQ-035 While rst_n=0 at a clock edge: FSM to IDLE, FIFO and in-flight count cleared, ARREADY=0, RVALID=0, RLAST=0, RID=0, RDATA=0, RRESP=00, ram_rd_en=0, ram_rd_addr=0, ram_rd_region=0.
REQ-036 Reset mid-burst SHALL discard the burst with no further beats; ARREADY=1 the first cycle after rst_n returns high.

Structure
REQ-037 Shared package axi_rd_pkg SHALL hold burst codes, RRESP codes, region codes and the FSM state enum.
REQ-038 Next-address logic SHALL be sub-module axi_rd_addr_gen (inputs addr, size, len, burst; output next addr).

Verification
REQ-039 INCR ARID=1 ARADDR=0 ARLEN=3 ARSIZE=2 region 1, RREADY=1 -> addresses 0,4,8,12; 4 beats on consecutive cycles, RID=1, OKAY, RLAST on 4th.
REQ-040 WRAP ARADDR=0x18 ARLEN=3 ARSIZE=2 -> addresses 0x18,0x1C,0x10,0x14.
REQ-041 INCR ARADDR=0x7FC ARLEN=1 ARSIZE=2 -> addresses 0x7FC then 0x000.
REQ-042 ARREGION=0 ARLEN=2 -> no ram_rd_en, 3 beats RDATA=0 RRESP=10, RLAST on 3rd.
REQ-043 ARLEN=7, RREADY toggled 1,0,0,1 repeating -> 8 beats in order, outputs stable while stalled, no RAM read lost or repeated.
REQ-044 rst_n=0 for one cycle after beat 2 of ARLEN=7 -> RVALID=0 next cycle, ARREADY=1 after release, new burst ARID=5 returns RID=5.
